// File: rtl/ssram_model_pkg.sv
// Shared types and helpers for the burst SSRAM model and the checkers that sit beside it.
package ssram_model_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  typedef enum logic {
    LINEAR      = 1'b0,
    INTERLEAVED = 1'b1
  } burst_order_e;

  // Low address bits of a burst beat; the caller masks the result to the burst length.
  function automatic logic [2:0] burst_addr(input logic [2:0] base,
                                            input logic [2:0] bc,
                                            input burst_order_e order);
    if (order == INTERLEAVED) return base ^ bc;
    return base + bc;
  endfunction

endpackage

// File: rtl/ssram_burst_ctr.sv
// Burst counter and effective-address generation for the SSRAM model.
module ssram_burst_ctr
  import ssram_model_pkg::*;
#(
  parameter int ADDR_WIDTH        = 19,
  parameter int BURST_LEN         = 4,
  parameter int BURST_INTERLEAVED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  adsc_n,
  input  logic                  advance_n,
  output logic [ADDR_WIDTH-1:0] ea
);

  localparam logic [2:0]            LOW_MASK  = 3'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(BURST_LEN - 1);
  localparam burst_order_e          ORDER     = (BURST_INTERLEAVED != 0) ? INTERLEAVED : LINEAR;

  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            bc;
  logic [2:0]            bc_eff;
  logic [2:0]            low;

  // An advancing cycle already addresses the next beat, so the count it uses is bc+1.
  always_comb begin
    bc_eff = advance_n ? bc : ((bc + 3'd1) & LOW_MASK);
    low    = burst_addr(base[2:0], bc_eff, ORDER) & LOW_MASK;
    if (!adsc_n) ea = address;
    else         ea = (base & ~ADDR_MASK) | {{(ADDR_WIDTH-3){1'b0}}, low};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      bc   <= '0;
    end else if (!adsc_n) begin
      base <= address;
      bc   <= '0;
    end else if (!advance_n) begin
      bc   <= bc_eff;
    end
  end

endmodule

// File: rtl/ssram_burst_model.sv
// Cycle-accurate pipelined burst SSRAM with a write-protected ROM window and a preload port.
module ssram_burst_model
  import ssram_model_pkg::*;
#(
  parameter int ADDR_WIDTH        = 19,
  parameter int DATA_WIDTH        = 32,
  parameter int RAM_WORDS         = 458752,
  parameter int ROM_WORDS         = 65536,
  parameter int BURST_LEN         = 4,
  parameter int BURST_INTERLEAVED = 1,
  parameter int READ_LATENCY      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   ssram_address,
  input  logic                    ssram_adsc_n,
  input  logic                    ssram_advance_n,
  input  logic                    ssram_writeen_n,
  input  logic [DATA_WIDTH/8-1:0] ssram_byteen_n,
  input  logic                    ssram_oe_n,
  input  logic [DATA_WIDTH-1:0]   ssram_data_i,
  output logic [DATA_WIDTH-1:0]   ssram_data_o,
  output logic                    ssram_data_oe,
  input  logic                    load_en,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    rom_write_err,
  output logic                    range_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int TOTAL = RAM_WORDS + ROM_WORDS;
  localparam int IW    = $clog2(TOTAL);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int LAT   = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;
  localparam logic [ADDR_WIDTH:0] RAM_END = AW1'(RAM_WORDS);
  localparam logic [ADDR_WIDTH:0] TOT_END = AW1'(TOTAL);

  logic [ADDR_WIDTH-1:0] ea;
  logic                  in_ram, in_rom, oor;
  logic                  bus_wr, bus_rd, any_be, ld_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [TOTAL];
  logic [LAT-1:0]        pv;
  logic [DATA_WIDTH-1:0] pd [LAT];

  ssram_burst_ctr #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .BURST_LEN         (BURST_LEN),
    .BURST_INTERLEAVED (BURST_INTERLEAVED)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .address   (ssram_address),
    .adsc_n    (ssram_adsc_n),
    .advance_n (ssram_advance_n),
    .ea        (ea)
  );

  assign in_ram  = {1'b0, ea} < RAM_END;
  assign oor     = !({1'b0, ea} < TOT_END);
  assign in_rom  = !in_ram && !oor;
  assign bus_wr  = !rst && !ssram_writeen_n;
  assign bus_rd  = !rst && ssram_writeen_n;
  assign any_be  = ~&ssram_byteen_n;
  assign ld_ok   = load_en && ({1'b0, load_addr} < TOT_END);
  assign rd_word = oor ? '0 : mem[ea[IW-1:0]];

  // Preload is written last so it overrides a same-cycle bus write to the same word.
  always_ff @(posedge clk) begin
    if (bus_wr && in_ram) begin
      for (int i = 0; i < NB; i++) begin
        if (!ssram_byteen_n[i]) mem[ea[IW-1:0]][8*i +: 8] <= ssram_data_i[8*i +: 8];
      end
    end
    if (ld_ok) mem[load_addr[IW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv            <= '0;
      rom_write_err <= 1'b0;
      range_err     <= 1'b0;
      for (int s = 0; s < LAT; s++) pd[s] <= '0;
    end else begin
      pv[0] <= bus_rd;
      if (bus_rd) pd[0] <= rd_word;
      for (int s = 1; s < LAT; s++) begin
        pv[s] <= pv[s-1];
        if (pv[s-1]) pd[s] <= pd[s-1];
      end
      rom_write_err <= bus_wr && in_rom && any_be;
      range_err     <= oor;
    end
  end

  assign ssram_data_o  = pd[LAT-1];
  assign ssram_data_oe = !ssram_oe_n && pv[LAT-1];

endmodule
